// File: rtl/st_pkt_buffer.sv
// Avalon-ST packet buffer: a circular buffer of DEPTH beats between a sink and
// a source. It runs in cut-through mode (MODE 0) or store-and-forward mode
// (MODE 1). Framing is checked on the sink side. Emitted packets are counted.
// irq and err are sticky flags.
// Ports:
//   clk_100_clk, reset_reset_n                       clock / async active-low reset
//   snk_data/valid/startofpacket/endofpacket/empty   Avalon-ST sink, snk_ready backpressure
//   src_data/valid/startofpacket/endofpacket/empty   Avalon-ST source, src_ready backpressure
//   irq_clr                                          pulse that clears irq and err
//   irq, err                                         sticky interrupt / framing error
//   level, pkt_count                                 entry count / emitted packet count
module st_pkt_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned MODE   = 0,
  localparam int unsigned EMPTY_W = (DATA_W > 8) ? $clog2(DATA_W / 8) : 1,
  localparam int unsigned LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk_100_clk,
  input  logic               reset_reset_n,
  input  logic [DATA_W-1:0]  snk_data,
  input  logic               snk_valid,
  input  logic               snk_startofpacket,
  input  logic               snk_endofpacket,
  input  logic [EMPTY_W-1:0] snk_empty,
  output logic               snk_ready,
  output logic [DATA_W-1:0]  src_data,
  output logic               src_valid,
  output logic               src_startofpacket,
  output logic               src_endofpacket,
  output logic [EMPTY_W-1:0] src_empty,
  input  logic               src_ready,
  input  logic               irq_clr,
  output logic               irq,
  output logic               err,
  output logic [LVL_W-1:0]   level,
  output logic [15:0]        pkt_count
);

  localparam int unsigned     PTR_W    = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam bit              SAF      = (MODE != 0);

  typedef struct packed {
    logic               eop;
    logic               sop;
    logic [EMPTY_W-1:0] empty;
    logic [DATA_W-1:0]  data;
  } entry_t;

  entry_t mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d, cpk_q, cpk_d;
  logic             in_pkt_q, in_pkt_d, drain_q, drain_d;
  logic             snk_ready_q, snk_ready_d, src_valid_q, src_valid_d;
  entry_t           src_q, src_d, wr_entry;
  logic [15:0]      pkt_count_q, pkt_count_d;
  logic             irq_q, irq_d, err_q, err_d;
  logic             accept, drop, restart, push, pop, pop_eop, err_set;

  // Handshake and framing decode
  always_comb begin
    wr_entry = '{eop: snk_endofpacket, sop: snk_startofpacket,
                 empty: snk_empty, data: snk_data};
    accept   = snk_valid & snk_ready_q;
    drop     = accept & ~in_pkt_q & ~snk_startofpacket;
    restart  = accept & in_pkt_q & snk_startofpacket;
    push     = accept & ~drop;
    pop      = src_valid_q & src_ready;
    pop_eop  = pop & src_q.eop;
    err_set  = drop | restart;
  end

  // Next-state computation
  always_comb begin
    level_d     = level_q;
    cpk_d       = cpk_q;
    in_pkt_d    = in_pkt_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;

    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !push) level_d = level_q - LVL_W'(1);

    if ((push && snk_endofpacket) && !pop_eop)      cpk_d = cpk_q + LVL_W'(1);
    else if (pop_eop && !(push && snk_endofpacket)) cpk_d = cpk_q - LVL_W'(1);

    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);

    if (push) begin
      if (snk_endofpacket)        in_pkt_d = 1'b0;
      else if (snk_startofpacket) in_pkt_d = 1'b1;
    end

    // A full buffer with no complete packet streams out until that packet's eop leaves
    drain_d     = SAF && ((drain_q && !pop_eop) || (level_d == FULL_LVL && cpk_d == '0));
    src_valid_d = (level_d != '0) && (!SAF || cpk_d != '0 || drain_d);

    // Bypass when the head entry is the one being written this cycle
    src_d       = (push && wr_ptr_q == rd_ptr_d) ? wr_entry : mem[rd_ptr_d];

    snk_ready_d = (level_d < FULL_LVL);
    pkt_count_d = pkt_count_q + 16'(pop_eop);
    err_d       = err_set ? 1'b1 : (irq_clr ? 1'b0 : err_q);
    irq_d       = (err_set || pop_eop) ? 1'b1 : (irq_clr ? 1'b0 : irq_q);
  end

  // Entry storage
  always_ff @(posedge clk_100_clk) begin
    if (push) mem[wr_ptr_q] <= wr_entry;
  end

  // State and registered outputs
  always_ff @(posedge clk_100_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      cpk_q       <= '0;
      in_pkt_q    <= 1'b0;
      drain_q     <= 1'b0;
      snk_ready_q <= 1'b0;
      src_valid_q <= 1'b0;
      src_q       <= '0;
      pkt_count_q <= '0;
      irq_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      cpk_q       <= cpk_d;
      in_pkt_q    <= in_pkt_d;
      drain_q     <= drain_d;
      snk_ready_q <= snk_ready_d;
      src_valid_q <= src_valid_d;
      src_q       <= src_d;
      pkt_count_q <= pkt_count_d;
      irq_q       <= irq_d;
      err_q       <= err_d;
    end
  end

  assign snk_ready         = snk_ready_q;
  assign src_valid         = src_valid_q;
  assign src_data          = src_q.data;
  assign src_startofpacket = src_q.sop;
  assign src_endofpacket   = src_q.eop;
  assign src_empty         = src_q.empty;
  assign level             = level_q;
  assign pkt_count         = pkt_count_q;
  assign irq               = irq_q;
  assign err               = err_q;

endmodule

// File: tb/tb_st_pkt_buffer.sv
// Directed bench for st_pkt_buffer. It drives three instances from shared inputs:
//   dut_a: MODE 0, DEPTH 64
//   dut_b: MODE 1, DEPTH 64
//   dut_c: MODE 1, DEPTH 4
// Each scenario resets all three instances and checks only the instance it targets.
module tb_st_pkt_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] snk_data;
  logic        snk_valid, snk_sop, snk_eop, src_ready, irq_clr;
  logic [1:0]  snk_empty;

  logic        a_snk_ready, a_src_valid, a_src_sop, a_src_eop, a_irq, a_err;
  logic [31:0] a_src_data;
  logic [1:0]  a_src_empty;
  logic [6:0]  a_level;
  logic [15:0] a_pkt_count;

  logic        b_snk_ready, b_src_valid, b_src_sop, b_src_eop, b_irq, b_err;
  logic [31:0] b_src_data;
  logic [1:0]  b_src_empty;
  logic [6:0]  b_level;
  logic [15:0] b_pkt_count;

  logic        c_snk_ready, c_src_valid, c_src_sop, c_src_eop, c_irq, c_err;
  logic [31:0] c_src_data;
  logic [1:0]  c_src_empty;
  logic [2:0]  c_level;
  logic [15:0] c_pkt_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  st_pkt_buffer #(.DATA_W(32), .DEPTH(64), .MODE(0)) dut_a (
    .clk_100_clk(clk), .reset_reset_n(rst_n),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_startofpacket(snk_sop),
    .snk_endofpacket(snk_eop), .snk_empty(snk_empty), .snk_ready(a_snk_ready),
    .src_data(a_src_data), .src_valid(a_src_valid), .src_startofpacket(a_src_sop),
    .src_endofpacket(a_src_eop), .src_empty(a_src_empty), .src_ready(src_ready),
    .irq_clr(irq_clr), .irq(a_irq), .err(a_err), .level(a_level), .pkt_count(a_pkt_count));

  st_pkt_buffer #(.DATA_W(32), .DEPTH(64), .MODE(1)) dut_b (
    .clk_100_clk(clk), .reset_reset_n(rst_n),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_startofpacket(snk_sop),
    .snk_endofpacket(snk_eop), .snk_empty(snk_empty), .snk_ready(b_snk_ready),
    .src_data(b_src_data), .src_valid(b_src_valid), .src_startofpacket(b_src_sop),
    .src_endofpacket(b_src_eop), .src_empty(b_src_empty), .src_ready(src_ready),
    .irq_clr(irq_clr), .irq(b_irq), .err(b_err), .level(b_level), .pkt_count(b_pkt_count));

  st_pkt_buffer #(.DATA_W(32), .DEPTH(4), .MODE(1)) dut_c (
    .clk_100_clk(clk), .reset_reset_n(rst_n),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_startofpacket(snk_sop),
    .snk_endofpacket(snk_eop), .snk_empty(snk_empty), .snk_ready(c_snk_ready),
    .src_data(c_src_data), .src_valid(c_src_valid), .src_startofpacket(c_src_sop),
    .src_endofpacket(c_src_eop), .src_empty(c_src_empty), .src_ready(src_ready),
    .irq_clr(irq_clr), .irq(c_irq), .err(c_err), .level(c_level), .pkt_count(c_pkt_count));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic s, input logic e);
    snk_valid = v;
    snk_data  = d;
    snk_sop   = s;
    snk_eop   = e;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    snk_empty = 2'd0;
    src_ready = 1'b0;
    irq_clr   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int sent;
    int got;
    logic acc;

    // Reset state, then snk_ready rises on the first edge after release
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    snk_empty = 2'd0;
    src_ready = 1'b0;
    irq_clr   = 1'b0;
    #2;
    chk("rst_snk_ready", 64'(a_snk_ready), 64'd0);
    chk("rst_src_valid", 64'(a_src_valid), 64'd0);
    chk("rst_level",     64'(a_level),     64'd0);
    chk("rst_irq_err",   64'({a_irq, a_err}), 64'd0);
    tick();
    rst_n = 1'b1;
    chk("rel_snk_ready_pre", 64'(a_snk_ready), 64'd0);
    tick();
    chk("rel_snk_ready", 64'(a_snk_ready), 64'd1);

    // Cut-through: 4-beat packet, each beat visible one cycle after acceptance
    do_reset();
    src_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hA0 + 32'(i), i == 0, i == 3);
      snk_empty = 2'(i);
      tick();
      chk("ct_valid", 64'(a_src_valid), 64'd1);
      chk("ct_data",  64'(a_src_data),  64'hA0 + 64'(i));
      chk("ct_sop",   64'(a_src_sop),   64'(i == 0));
      chk("ct_eop",   64'(a_src_eop),   64'(i == 3));
      chk("ct_empty", 64'(a_src_empty), 64'(i));
      chk("ct_level", 64'(a_level),     64'd1);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    snk_empty = 2'd0;
    tick();
    chk("ct_done_valid", 64'(a_src_valid), 64'd0);
    chk("ct_done_level", 64'(a_level),     64'd0);
    chk("ct_pkt_count",  64'(a_pkt_count), 64'd1);
    chk("ct_irq",        64'(a_irq),       64'd1);
    chk("ct_err",        64'(a_err),       64'd0);

    // Store-and-forward: 10-beat packet is held until its eop is stored
    do_reset();
    src_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'hB0 + 32'(i), i == 0, i == 9);
      tick();
      chk("sf_hold_valid", 64'(b_src_valid), 64'(i == 9));
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("sf_first_data", 64'(b_src_data), 64'hB0);
    chk("sf_level", 64'(b_level), 64'd10);
    for (int k = 1; k < 10; k++) begin
      tick();
      chk("sf_stream_valid", 64'(b_src_valid), 64'd1);
      chk("sf_stream_data",  64'(b_src_data),  64'hB0 + 64'(k));
    end
    chk("sf_last_eop", 64'(b_src_eop), 64'd1);
    tick();
    chk("sf_done_valid", 64'(b_src_valid), 64'd0);
    chk("sf_pkt_count",  64'(b_pkt_count), 64'd1);

    // Full buffer (DEPTH 4, src_ready=0): 6 beats offered, then one pop
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'hC0 + 32'(i), i == 0, 1'b0);
      tick();
      chk("full_level",     64'(c_level),     (i < 4) ? 64'(i + 1) : 64'd4);
      chk("full_snk_ready", 64'(c_snk_ready), 64'(i < 3));
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("full_src_valid", 64'(c_src_valid), 64'd1);
    chk("full_head",      64'(c_src_data),  64'hC0);
    src_ready = 1'b1;
    tick();
    src_ready = 1'b0;
    chk("pop_level",     64'(c_level),     64'd3);
    chk("pop_snk_ready", 64'(c_snk_ready), 64'd1);
    chk("pop_next_data", 64'(c_src_data),  64'hC1);

    // Oversized packet in store-and-forward (DEPTH 4): 7 beats drain in order
    do_reset();
    src_ready = 1'b1;
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 100 && got < 7; cyc++) begin
      if (sent < 7) drive(1'b1, 32'hD0 + 32'(sent), sent == 0, sent == 6);
      else          drive(1'b0, 32'h0, 1'b0, 1'b0);
      acc = snk_valid && c_snk_ready;
      if (c_src_valid && src_ready) begin
        chk("ovs_data", 64'(c_src_data), 64'hD0 + 64'(got));
        chk("ovs_eop",  64'(c_src_eop),  64'(got == 6));
        got++;
      end
      tick();
      if (acc) sent++;
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("ovs_emitted",   64'(got),         64'd7);
    chk("ovs_pkt_count", 64'(c_pkt_count), 64'd1);
    chk("ovs_level",     64'(c_level),     64'd0);

    // Framing: stray beat dropped, irq_clr clears, set wins over clear
    do_reset();
    drive(1'b1, 32'hEE, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("frm_level", 64'(a_level), 64'd0);
    chk("frm_err",   64'(a_err),   64'd1);
    chk("frm_irq",   64'(a_irq),   64'd1);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    chk("clr_irq_err", 64'({a_irq, a_err}), 64'd0);
    src_ready = 1'b1;
    drive(1'b1, 32'h55, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("one_beat_valid", 64'({a_src_valid, a_src_sop, a_src_eop}), 64'b111);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    chk("set_wins_irq",  64'(a_irq),       64'd1);
    chk("one_beat_pkts", 64'(a_pkt_count), 64'd1);

    // Reset mid-operation with 3 buffered beats
    src_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hF0 + 32'(i), i == 0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("mid_level_pre", 64'(a_level), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_level",     64'(a_level),     64'd0);
    chk("mid_src_valid", 64'(a_src_valid), 64'd0);
    chk("mid_pkt_count", 64'(a_pkt_count), 64'd0);
    chk("mid_snk_ready", 64'(a_snk_ready), 64'd0);
    chk("mid_irq",       64'(a_irq),       64'd0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("mid_rel_ready", 64'(a_snk_ready), 64'd1);
    drive(1'b1, 32'h77, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("mid_drop_level", 64'(a_level), 64'd0);
    chk("mid_drop_err",   64'(a_err),   64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/st_pkt_buffer.md
ST_PKT_BUFFER -- requirements
Module: st_pkt_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning stream data width in bits; legal values 8, 16, 32, 64, 128.
REQ-002 SHALL have parameter DEPTH, default 64, meaning buffer entries; legal values are powers of 2 from 4 to 1024.
REQ-003 SHALL have parameter MODE, default 0, meaning 0 = cut-through and 1 = store-and-forward.
REQ-004 SHALL use derived widths EMPTY_W = log2(DATA_W/8) (minimum 1) and LVL_W = log2(DEPTH)+1.
REQ-005 SHALL have clk_100_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have reset_reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have snk_data/snk_valid/snk_startofpacket/snk_endofpacket/snk_empty, inputs, DATA_W/1/1/1/EMPTY_W, the Avalon-ST sink.
REQ-008 SHALL have snk_ready, output, 1, sink backpressure, ready latency 0.
REQ-009 SHALL have src_data/src_valid/src_startofpacket/src_endofpacket/src_empty, outputs, DATA_W/1/1/1/EMPTY_W, the Avalon-ST source.
REQ-010 SHALL have src_ready, input, 1, source backpressure, ready latency 0.
REQ-011 SHALL have irq_clr, input, 1, a single-cycle pulse that clears irq and err.
REQ-012 SHALL have irq, output, 1, sticky interrupt.
REQ-013 SHALL have err, output, 1, sticky framing error.
REQ-014 SHALL have level, output, LVL_W, current entry count.
REQ-015 SHALL have pkt_count, output, 16, count of packets fully emitted on the source.

Function
REQ-016 SHALL store data, sop, eop and empty per entry in a circular buffer of DEPTH entries; read and write pointers wrap from DEPTH-1 to 0.
REQ-017 SHALL accept a sink beat only when snk_valid and snk_ready are both 1.
REQ-018 SHALL drive snk_ready = 1 exactly when level < DEPTH; a beat is never written when full, even if a pop occurs in the same cycle.
REQ-019 SHALL emit a source beat only when src_valid and src_ready are both 1.
REQ-020 SHALL hold src_data/sop/eop/empty stable while src_valid=1 and src_ready=0.
REQ-021 SHALL track an in_pkt flag with this framing rule: a beat accepted with in_pkt=0 and sop=0 is dropped (not stored) and sets err.
REQ-022 SHALL, for a beat with sop=1 accepted while in_pkt=1, store the beat, set err, and restart the packet.
REQ-023 SHALL set in_pkt on a stored sop beat and clear it on a stored eop beat; a beat with sop=1 and eop=1 forms a one-beat packet.
REQ-024 SHALL pass snk_empty through unmodified; for EMPTY_W derived from DATA_W=8 the field is stored but meaningless.
REQ-025 SHALL, in MODE 0, assert src_valid whenever level > 0; a beat accepted at edge N is visible on the source from edge N+1.
REQ-026 SHALL, in MODE 1, assert src_valid only when complete_pkts > 0 or level == DEPTH.
REQ-027 SHALL increment complete_pkts on each stored eop beat and decrement it on each emitted eop beat; both events in the same cycle leave it unchanged.
REQ-028 SHALL, in MODE 1 when level == DEPTH with no complete packet, release beats as in cut-through until the in-flight eop is emitted, so oversized packets cannot deadlock.
REQ-029 SHALL increment level on push only, decrement on pop only, and leave it unchanged on simultaneous push and pop.
REQ-030 SHALL increment pkt_count on every emitted eop beat, wrapping modulo 2^16.
REQ-031 SHALL set irq on an emitted eop beat or on any err-setting event.
REQ-032 SHALL clear irq and err on irq_clr; when a set event and irq_clr occur in the same cycle, set wins.

Reset
REQ-033 SHALL, while reset_reset_n=0, immediately force: snk_ready=0, src_valid=0, src_sop/eop/empty/data=0, level=0, pkt_count=0, irq=0, err=0, and pointers, in_pkt and complete_pkts to 0.
REQ-034 SHALL drive snk_ready=1 from the first clock edge after reset release.
REQ-035 SHALL, on reset mid-packet, discard all buffered data; the next accepted beat without sop is dropped and sets err.

Verification
REQ-036 SHALL verify cut-through (MODE 0, DEPTH 64): a 4-beat packet with src_ready=1 -> each beat appears one cycle after acceptance, pkt_count=1, irq=1.
REQ-037 SHALL verify store-and-forward (MODE 1): a 10-beat packet -> src_valid stays 0 until the cycle after the eop is accepted, then 10 contiguous beats are emitted.
REQ-038 SHALL verify full buffer (DEPTH 4, src_ready=0): 6 beats offered -> snk_ready=0 after 4 beats and level=4; one pop -> level=3 and snk_ready=1.
REQ-039 SHALL verify the MODE 1 oversize case (DEPTH 4): a 7-beat packet -> no deadlock, all 7 beats emitted in order, pkt_count=1.
REQ-040 SHALL verify framing: a beat with sop=0 while idle -> dropped, level unchanged, err=1, irq=1; irq_clr -> both 0; irq_clr coinciding with an eop pop -> irq stays 1.
REQ-041 SHALL verify reset mid-operation: reset asserted with level=3 -> level=0, src_valid=0, pkt_count=0 immediately.
